// File: rtl/ahb_lite_downsizer_if.sv
// Bundles the bus-side slave port and the device-side master port of the downsizer.
// The slave modport is the downsizer's view, the master modport the surrounding fabric's view.
interface ahb_lite_downsizer_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32,
  parameter int DDATA_WIDTH = 8
);
  logic                   s_HSEL;
  logic [HADDR_WIDTH-1:0] s_HADDR;
  logic [1:0]             s_HTRANS;
  logic                   s_HWRITE;
  logic [2:0]             s_HSIZE;
  logic [HDATA_WIDTH-1:0] s_HWDATA;
  logic                   s_HREADY;
  logic [HDATA_WIDTH-1:0] s_HRDATA;
  logic                   s_HREADYOUT;
  logic                   s_HRESP;

  logic [HADDR_WIDTH-1:0] m_HADDR;
  logic [1:0]             m_HTRANS;
  logic                   m_HWRITE;
  logic [2:0]             m_HSIZE;
  logic [DDATA_WIDTH-1:0] m_HWDATA;
  logic [DDATA_WIDTH-1:0] m_HRDATA;
  logic                   m_HREADY;
  logic                   m_HRESP;

  modport slave (
    input  s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HWDATA, s_HREADY,
    output s_HRDATA, s_HREADYOUT, s_HRESP,
    output m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HWDATA,
    input  m_HRDATA, m_HREADY, m_HRESP
  );

  modport master (
    output s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HWDATA, s_HREADY,
    input  s_HRDATA, s_HREADYOUT, s_HRESP,
    input  m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HWDATA,
    output m_HRDATA, m_HREADY, m_HRESP
  );
endinterface

// File: rtl/ahb_lite_downsizer.sv
// AHB-Lite width converter: splits wide bus transfers into sequential narrow device beats,
// assembling read data and forwarding device errors while holding the bus in wait states.
module ahb_lite_downsizer #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32,
  parameter int DDATA_WIDTH = 8
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  ahb_lite_downsizer_if.slave ahb
);
  localparam int NL     = HDATA_WIDTH / DDATA_WIDTH;
  localparam int DBYTES = DDATA_WIDTH / 8;
  localparam int DS     = $clog2(DBYTES);
  localparam int BL     = $clog2(HDATA_WIDTH / 8);
  localparam int LW     = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q;
  logic                   aph_valid_q;
  logic                   dph_valid_q;
  logic                   write_q;
  logic [HADDR_WIDTH-1:0] addr_q;
  logic [2:0]             size_q;
  logic [LW-1:0]          last_q;
  logic [LW-1:0]          a_idx_q;
  logic [LW-1:0]          d_idx_q;
  logic [LW-1:0]          base_lane_q;
  logic [DDATA_WIDTH-1:0] rdata_q [NL];

  logic                   accept;
  logic                   hreadyout;
  logic                   last_dph;
  logic                   err;
  logic [LW-1:0]          dph_lane;
  logic [LW-1:0]          acc_lane;
  logic [LW-1:0]          acc_last;
  logic [2:0]             acc_size;
  logic [HADDR_WIDTH-1:0] acc_addr;
  logic [DDATA_WIDTH-1:0] wlane [NL];

  assign last_dph  = (d_idx_q == last_q);
  assign err       = (state_q == BUSY) && dph_valid_q && ahb.m_HRESP;
  assign hreadyout = (state_q == IDLE) ||
                     (dph_valid_q && ahb.m_HREADY && (last_dph || ahb.m_HRESP));
  assign accept    = ahb.s_HSEL && ahb.s_HREADY && ahb.s_HTRANS[1] && hreadyout;
  assign dph_lane  = base_lane_q + d_idx_q;

  // Multi-beat transfers start from the size-aligned base; single beats keep the raw address.
  always_comb begin
    acc_size = (int'(ahb.s_HSIZE) > BL) ? 3'(BL) : ahb.s_HSIZE;
    acc_last = '0;
    acc_addr = ahb.s_HADDR;
    if (int'(acc_size) > DS) begin
      acc_last = LW'((1 << (int'(acc_size) - DS)) - 1);
      acc_addr = ahb.s_HADDR & ~HADDR_WIDTH'((1 << int'(acc_size)) - 1);
    end
  end

  generate
    if (NL > 1) begin : g_lane
      assign acc_lane = acc_addr[BL-1:DS];
    end else begin : g_nolane
      assign acc_lane = '0;
    end
  endgenerate

  assign ahb.m_HADDR     = addr_q;
  assign ahb.m_HTRANS    = aph_valid_q ? 2'b10 : 2'b00;
  assign ahb.m_HWRITE    = write_q;
  assign ahb.m_HSIZE     = size_q;
  assign ahb.m_HWDATA    = (dph_valid_q && write_q) ? wlane[dph_lane] : '0;
  assign ahb.s_HREADYOUT = hreadyout;
  assign ahb.s_HRESP     = err;

  // The beat in its data phase is forwarded live; single-beat reads fan out to every lane.
  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lanes
      assign wlane[gi] = ahb.s_HWDATA[gi*DDATA_WIDTH +: DDATA_WIDTH];
      assign ahb.s_HRDATA[gi*DDATA_WIDTH +: DDATA_WIDTH] =
        (dph_valid_q && ((last_q == '0) || (dph_lane == LW'(gi)))) ? ahb.m_HRDATA : rdata_q[gi];
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      aph_valid_q <= 1'b0;
      dph_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      last_q      <= '0;
      a_idx_q     <= '0;
      d_idx_q     <= '0;
      base_lane_q <= '0;
      for (int i = 0; i < NL; i++) rdata_q[i] <= '0;
    end else begin
      if (err) begin
        // First error cycle cancels the pending beat; second cycle ends the transfer.
        aph_valid_q <= 1'b0;
        if (ahb.m_HREADY) begin
          dph_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      end else if (state_q == BUSY && ahb.m_HREADY) begin
        if (dph_valid_q && !last_dph && !write_q) rdata_q[dph_lane] <= ahb.m_HRDATA;
        dph_valid_q <= aph_valid_q;
        d_idx_q     <= a_idx_q;
        if (aph_valid_q) begin
          if (a_idx_q == last_q) begin
            aph_valid_q <= 1'b0;
          end else begin
            a_idx_q <= a_idx_q + 1'b1;
            addr_q  <= addr_q + HADDR_WIDTH'(DBYTES);
          end
        end
        if (dph_valid_q && last_dph) state_q <= IDLE;
      end

      if (accept) begin
        state_q     <= BUSY;
        aph_valid_q <= 1'b1;
        dph_valid_q <= 1'b0;
        a_idx_q     <= '0;
        d_idx_q     <= '0;
        addr_q      <= acc_addr;
        write_q     <= ahb.s_HWRITE;
        size_q      <= (int'(acc_size) > DS) ? 3'(DS) : acc_size;
        last_q      <= acc_last;
        base_lane_q <= acc_lane;
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_downsizer.sv
// Directed bench for the 32-to-8 bit AHB-Lite downsizer with hand-computed expectations.
module tb_ahb_lite_downsizer;
  localparam int AW = 32;
  localparam int HW = 32;
  localparam int DW = 8;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [AW-1:0] dev_log [$];

  always #5 HCLK = ~HCLK;

  ahb_lite_downsizer_if #(.HADDR_WIDTH(AW), .HDATA_WIDTH(HW), .DDATA_WIDTH(DW)) ahb ();

  ahb_lite_downsizer #(.HADDR_WIDTH(AW), .HDATA_WIDTH(HW), .DDATA_WIDTH(DW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (ahb)
  );

  // The downsizer is the only slave, so global HREADY follows its HREADYOUT.
  assign ahb.s_HREADY = ahb.s_HREADYOUT;

  // Device-side log of every address phase the device actually accepts.
  always @(posedge HCLK)
    if (HRESETn && ahb.m_HTRANS[1] && ahb.m_HREADY) dev_log.push_back(ahb.m_HADDR);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic dev(input logic rdy, input logic resp, input logic [7:0] rd);
    ahb.m_HREADY = rdy;
    ahb.m_HRESP  = resp;
    ahb.m_HRDATA = rd;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [2:0] sz);
    ahb.s_HSEL   = 1'b1;
    ahb.s_HADDR  = a;
    ahb.s_HTRANS = 2'b10;
    ahb.s_HWRITE = w;
    ahb.s_HSIZE  = sz;
  endtask

  task automatic noreq();
    ahb.s_HSEL   = 1'b0;
    ahb.s_HTRANS = 2'b00;
  endtask

  task automatic chk_log(input string tag, input logic [31:0] first, input int n);
    chk({tag, "_cnt"}, 64'(dev_log.size()), 64'(n));
    for (int i = 0; i < n && i < dev_log.size(); i++)
      chk($sformatf("%s_a%0d", tag, i), 64'(dev_log[i]), 64'(first + i));
    dev_log.delete();
  endtask

  // Zero-wait word read already in its bus address phase; optionally chains the next request.
  task automatic word_read_zw(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input bit chain, input logic [31:0] na);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) noreq();
      dev(1'b1, 1'b0, (c >= 2) ? d[(c-2)*8 +: 8] : 8'h00);
      if (c == 5 && chain) req(na, 1'b0, 3'd2);
      #2;
      if (c == 1) begin
        chk({tag, "_addr0"}, 64'(ahb.m_HADDR), 64'(a));
        chk({tag, "_trans0"}, 64'(ahb.m_HTRANS), 64'h2);
      end
      chk($sformatf("%s_rdy%0d", tag, c), 64'(ahb.s_HREADYOUT), 64'(c == 5));
      if (c == 5) chk({tag, "_rdata"}, 64'(ahb.s_HRDATA), 64'(d));
    end
    $display("txn %s read 0x%0h -> 0x%0h", tag, a, ahb.s_HRDATA);
  endtask

  logic [7:0]  wb    [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic        t2_rdy[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0]  t2_rd [6] = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h33, 8'h44};

  initial begin
    int waits;
    HRESETn = 1'b0;
    noreq();
    ahb.s_HADDR = '0; ahb.s_HWRITE = 1'b0; ahb.s_HSIZE = '0; ahb.s_HWDATA = '0;
    dev(1'b1, 1'b0, 8'h00);
    repeat (2) cyc();
    #2;
    chk("rst_readyout", 64'(ahb.s_HREADYOUT), 64'h1);
    chk("rst_hresp",    64'(ahb.s_HRESP),     64'h0);
    chk("rst_hrdata",   64'(ahb.s_HRDATA),    64'h0);
    chk("rst_mtrans",   64'(ahb.m_HTRANS),    64'h0);
    chk("rst_maddr",    64'(ahb.m_HADDR),     64'h0);
    chk("rst_mwrite",   64'(ahb.m_HWRITE),    64'h0);
    chk("rst_msize",    64'(ahb.m_HSIZE),     64'h0);
    chk("rst_mwdata",   64'(ahb.m_HWDATA),    64'h0);
    cyc();
    HRESETn = 1'b1;

    // Selected IDLE transfer: no device activity, no wait state.
    cyc();
    ahb.s_HSEL = 1'b1; ahb.s_HTRANS = 2'b00;
    cyc();
    noreq();
    #2;
    chk("idle_trans", 64'(ahb.m_HTRANS), 64'h0);
    chk("idle_ready", 64'(ahb.s_HREADYOUT), 64'h1);
    $display("txn idle transfer");

    // Word write 0x100, zero-wait device.
    req(32'h100, 1'b1, 3'd2);
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 0) begin noreq(); ahb.s_HWDATA = 32'hDDCCBBAA; end
      #2;
      chk($sformatf("ww_rdy%0d", k), 64'(ahb.s_HREADYOUT), 64'(k == 4));
      if (k < 4) begin
        chk($sformatf("ww_addr%0d", k), 64'(ahb.m_HADDR), 64'(32'h100 + k));
        chk($sformatf("ww_trans%0d", k), 64'(ahb.m_HTRANS), 64'h2);
        chk($sformatf("ww_size%0d", k), 64'(ahb.m_HSIZE), 64'h0);
        chk($sformatf("ww_write%0d", k), 64'(ahb.m_HWRITE), 64'h1);
      end else begin
        chk("ww_trans_end", 64'(ahb.m_HTRANS), 64'h0);
      end
      if (k > 0) chk($sformatf("ww_wdata%0d", k - 1), 64'(ahb.m_HWDATA), 64'(wb[k-1]));
    end
    chk_log("ww_log", 32'h100, 4);
    $display("txn word write 0x100 data 0xddccbbaa");

    // Word read 0x204, one device wait on beat 2.
    cyc();
    req(32'h204, 1'b0, 3'd2);
    waits = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c == 0) noreq();
      dev(t2_rdy[c], 1'b0, t2_rd[c]);
      #2;
      if (!ahb.s_HREADYOUT) waits++;
      if (c == 5) begin
        chk("wr_ready_end", 64'(ahb.s_HREADYOUT), 64'h1);
        chk("wr_rdata", 64'(ahb.s_HRDATA), 64'h44332211);
        chk("wr_trans_end", 64'(ahb.m_HTRANS), 64'h0);
      end
    end
    chk("wr_waits", 64'(waits), 64'd5);
    chk_log("wr_log", 32'h204, 4);
    $display("txn word read 0x204 -> 0x%0h waits %0d", ahb.s_HRDATA, waits);

    // Byte write 0x003.
    cyc();
    dev(1'b1, 1'b0, 8'h00);
    req(32'h003, 1'b1, 3'd0);
    cyc();
    noreq(); ahb.s_HWDATA = 32'h5A000000;
    #2;
    chk("bw_addr", 64'(ahb.m_HADDR), 64'h3);
    chk("bw_ready0", 64'(ahb.s_HREADYOUT), 64'h0);
    cyc();
    #2;
    chk("bw_wdata", 64'(ahb.m_HWDATA), 64'h5A);
    chk("bw_ready1", 64'(ahb.s_HREADYOUT), 64'h1);
    $display("txn byte write 0x003 data 0x5a");

    // Byte read 0x001.
    cyc();
    req(32'h001, 1'b0, 3'd0);
    cyc();
    noreq();
    #2;
    chk("br_addr", 64'(ahb.m_HADDR), 64'h1);
    cyc();
    dev(1'b1, 1'b0, 8'h7E);
    #2;
    chk("br_ready", 64'(ahb.s_HREADYOUT), 64'h1);
    chk("br_rdata", 64'(ahb.s_HRDATA), 64'h7E7E7E7E);
    $display("txn byte read 0x001 -> 0x%0h", ahb.s_HRDATA);
    dev_log.delete();

    // Halfword read 0x00A.
    cyc();
    dev(1'b1, 1'b0, 8'h00);
    req(32'h00A, 1'b0, 3'd1);
    cyc();
    noreq();
    #2;
    chk("hr_addr0", 64'(ahb.m_HADDR), 64'hA);
    chk("hr_size", 64'(ahb.m_HSIZE), 64'h0);
    cyc();
    dev(1'b1, 1'b0, 8'h34);
    #2;
    chk("hr_addr1", 64'(ahb.m_HADDR), 64'hB);
    chk("hr_ready0", 64'(ahb.s_HREADYOUT), 64'h0);
    cyc();
    dev(1'b1, 1'b0, 8'h12);
    #2;
    chk("hr_ready1", 64'(ahb.s_HREADYOUT), 64'h1);
    chk("hr_rdata_hi", 64'(ahb.s_HRDATA[31:16]), 64'h1234);
    $display("txn halfword read 0x00a -> 0x%0h", ahb.s_HRDATA[31:16]);
    dev_log.delete();

    // Word write 0x100 with device ERROR on beat 1.
    cyc();
    dev(1'b1, 1'b0, 8'h00);
    req(32'h100, 1'b1, 3'd2);
    cyc();
    noreq(); ahb.s_HWDATA = 32'hDDCCBBAA;
    cyc();
    cyc();
    dev(1'b0, 1'b1, 8'h00);
    #2;
    chk("er1_hresp", 64'(ahb.s_HRESP), 64'h1);
    chk("er1_ready", 64'(ahb.s_HREADYOUT), 64'h0);
    chk("er1_addr", 64'(ahb.m_HADDR), 64'h102);
    cyc();
    dev(1'b1, 1'b1, 8'h00);
    #2;
    chk("er2_hresp", 64'(ahb.s_HRESP), 64'h1);
    chk("er2_ready", 64'(ahb.s_HREADYOUT), 64'h1);
    chk("er2_trans", 64'(ahb.m_HTRANS), 64'h0);
    cyc();
    dev(1'b1, 1'b0, 8'h00);
    #2;
    chk("er3_hresp", 64'(ahb.s_HRESP), 64'h0);
    chk("er3_trans", 64'(ahb.m_HTRANS), 64'h0);
    chk_log("er_log", 32'h100, 2);
    $display("txn word write 0x100 error on beat 1");

    // Reset during beat 2 of a word read, then recovery and a back-to-back pair.
    cyc();
    req(32'h200, 1'b0, 3'd2);
    cyc();
    noreq();
    repeat (3) cyc();
    HRESETn = 1'b0;
    #2;
    chk("mr_trans", 64'(ahb.m_HTRANS), 64'h0);
    chk("mr_ready", 64'(ahb.s_HREADYOUT), 64'h1);
    chk("mr_addr", 64'(ahb.m_HADDR), 64'h0);
    $display("txn word read 0x200 reset mid-transfer");
    cyc();
    HRESETn = 1'b1;
    dev_log.delete();
    req(32'h300, 1'b0, 3'd2);
    word_read_zw("rr300", 32'h300, 32'hA4A3A2A1, 1'b1, 32'h400);
    chk_log("rr300_log", 32'h300, 4);
    word_read_zw("b2b400", 32'h400, 32'hB4B3B2B1, 1'b0, 32'h0);
    chk_log("b2b400_log", 32'h400, 4);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ahb_lite_downsizer.md
Name: ahb_lite_downsizer

Overview:
AHB-Lite width converter between a wide bus-side slave port and a narrow device-side master port. It splits any transfer wider than the device into sequential narrow beats, stalling the bus with wait states. Read data is assembled across beats and device errors are forwarded to the bus. It sits between the AHB-Lite interconnect and narrow peripherals (8/16-bit) where zero-wait lane muxing is insufficient.

Parameters:
HADDR_WIDTH, 32, address width on both sides
HDATA_WIDTH, 32, bus-side data width; power of 2, >= DDATA_WIDTH
DDATA_WIDTH, 8, device-side data width; power of 2, >= 8

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
s_HSEL  in  1  slave select
s_HADDR  in  HADDR_WIDTH  bus address
s_HTRANS  in  2  bus transfer type
s_HWRITE  in  1  bus write
s_HSIZE  in  3  bus transfer size (log2 bytes)
s_HWDATA  in  HDATA_WIDTH  bus write data
s_HREADY  in  1  global bus HREADY
s_HRDATA  out  HDATA_WIDTH  bus read data
s_HREADYOUT  out  1  bus-side ready
s_HRESP  out  1  bus-side response (1=ERROR)
m_HADDR  out  HADDR_WIDTH  device address
m_HTRANS  out  2  device transfer type
m_HWRITE  out  1  device write
m_HSIZE  out  3  device transfer size
m_HWDATA  out  DDATA_WIDTH  device write data
m_HRDATA  in  DDATA_WIDTH  device read data
m_HREADY  in  1  device HREADYOUT
m_HRESP  in  1  device response

Behaviour:
- DS = log2(DDATA_WIDTH/8). Lane index = address bits [log2(HDATA_WIDTH/8)-1 : DS].
- Accept: s_HSEL & s_HREADY & s_HTRANS[1]. Latch addr, write, size, and beat count N = 2^(HSIZE-DS) if HSIZE > DS, else 1.
- IDLE/BUSY transfers and unselected cycles: zero-wait OKAY, no device activity.
- States: IDLE, BUSY. IDLE->BUSY on accept. BUSY->IDLE when the last beat's data phase completes (m_HREADY=1) or on an error. BUSY->BUSY on a new accept in that same completing cycle.
- Beat k address phase: m_HTRANS=NONSEQ, m_HADDR=aligned base+k*DDATA_WIDTH/8, m_HSIZE=min(HSIZE,DS), m_HWRITE=latched.
- Single-beat transfers keep the original address.
- Beat 0 address is presented the cycle after accept (registered). Beat k+1 address overlaps beat k data phase and advances only when m_HREADY=1.
- m_HTRANS=IDLE when no beat is pending.
- Write data: m_HWDATA = s_HWDATA lane (base lane + data-phase beat index), combinational. s_HWDATA is held by the master during wait states.
- Read data:
  - Beats 0..N-2 are captured into the lane register on m_HREADY.
  - s_HRDATA = register lanes, with the current beat lane driven combinationally from m_HRDATA.
  - Single narrow beat: m_HRDATA replicated across all lanes.
- Ready: s_HREADYOUT=0 throughout BUSY until the last beat's m_HREADY=1 cycle, then s_HREADYOUT=1 in that same cycle (combinational).
- Minimum bus data phase is N+1 cycles (N wait states) plus device wait states.
- Device ERROR on beat k:
  - Cycle 1 (m_HRESP=1, m_HREADY=0): s_HRESP=1, s_HREADYOUT=0.
  - Cycle 2 (m_HRESP=1, m_HREADY=1): s_HRESP=1, s_HREADYOUT=1, m_HTRANS forced IDLE (cancels pending beat k+1), remaining beats dropped, return to IDLE.
- Reset values: s_HREADYOUT=1, s_HRESP=0, s_HRDATA=0, m_HTRANS=IDLE, m_HADDR=0, m_HWRITE=0, m_HSIZE=0, m_HWDATA=0, beat counter=0, state IDLE.
- Reset mid-transfer drops all pending beats immediately; the first post-reset transfer starts at beat 0.
- HDATA_WIDTH==DDATA_WIDTH: always N=1, pure registered pass-through with 1 wait state.

Test Plan:
- Word write to 0x100, data 0xDDCCBBAA, zero-wait device -> m beats at 0x100..0x103, HSIZE=0, NONSEQ; m_HWDATA AA,BB,CC,DD; s_HREADYOUT low 4 cycles, high on the 5th.
- Word read 0x204, device returns 11,22,33,44 with 1 wait on beat 2 -> s_HRDATA=0x44332211 on the completing cycle; 5 total bus wait states.
- Byte write 0x003, s_HWDATA=0x5A000000 -> single beat at 0x003, m_HWDATA=0x5A. Byte read 0x001 returning 0x7E -> s_HRDATA=0x7E7E7E7E.
- Halfword read 0x00A -> beats at 0x00A and 0x00B; device returns 0x34, 0x12 -> s_HRDATA[31:16]=0x1234.
- Device ERROR on beat 1 of word write 0x100 -> s_HRESP high 2 cycles (READYOUT 0 then 1); m_HTRANS=IDLE in error cycle 2; addresses 0x102/0x103 never accepted.
- HRESETn low during beat 2 of a word read -> m_HTRANS=IDLE, s_HREADYOUT=1 immediately. Next word read at 0x300 issues beats 0x300..0x303 correctly. Back-to-back accept on the completing cycle also tested.
